// File: rtl/spi_sram_slave.sv
// SPI-to-SRAM bridge: 24-bit frames (opcode, address, data) clocked by sck.
// Optional build macro SPI_SRAM_AUTOINC_EN enables burst access with address auto-increment.
module spi_sram_slave (
  input  logic       sck,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;

  state_t     state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [7:0] sh, sh_n, sh_in;
  logic [7:0] rd, rd_n;
  logic       is_rd, is_rd_n;
  logic [4:0] addr, addr_n;
  logic       we_n, re_n;
  logic [4:0] maddr_n;
  logic [7:0] wdata_n;

  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      rd        <= '0;
      is_rd     <= 1'b0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      rd        <= rd_n;
      is_rd     <= is_rd_n;
      addr      <= addr_n;
      mem_we    <= we_n;
      mem_re    <= re_n;
      mem_addr  <= maddr_n;
      mem_wdata <= wdata_n;
    end
  end

  always_comb begin
    sh_in   = {sh[6:0], mosi};
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    rd_n    = rd;
    is_rd_n = is_rd;
    addr_n  = addr;
    we_n    = 1'b0;
    re_n    = 1'b0;
    maddr_n = mem_addr;
    wdata_n = mem_wdata;

    if (cs_n) begin
      state_n = IDLE;
      cnt_n   = '0;
      sh_n    = '0;
      rd_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = CMD;
          cnt_n   = 5'd1;
          sh_n    = {7'b0, mosi};
          rd_n    = '0;
          is_rd_n = 1'b0;
        end
        CMD: begin
          sh_n  = sh_in;
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd7) begin
            if (sh_in == OP_WRITE || sh_in == OP_READ) begin
              state_n = ADDR;
              is_rd_n = (sh_in == OP_READ);
            end else begin
              state_n = DONE;
            end
          end
        end
        ADDR: begin
          sh_n  = sh_in;
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd15) begin
            state_n = DATA;
            addr_n  = sh_in[4:0];
            if (is_rd) begin
              re_n    = 1'b1;
              maddr_n = sh_in[4:0];
            end
          end
        end
        DATA: begin
          sh_n  = sh_in;
          cnt_n = cnt + 5'd1;
          // The read strobe cycle is the one where mem_rdata is valid; capture it on this edge
          if (mem_re) rd_n = mem_rdata;
          else        rd_n = {rd[6:0], 1'b0};
          if (cnt == 5'd23) begin
            if (!is_rd) begin
              we_n    = 1'b1;
              maddr_n = addr;
              wdata_n = sh_in;
            end
`ifdef SPI_SRAM_AUTOINC_EN
            // Burst: rewind the counter to the start of the data byte and advance the address
            cnt_n  = 5'd16;
            addr_n = addr + 5'd1;
            if (is_rd) begin
              re_n    = 1'b1;
              maddr_n = addr + 5'd1;
            end
`else
            state_n = DONE;
`endif
          end
        end
        DONE: begin
          rd_n = {rd[6:0], 1'b0};
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign miso = rd[7];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_sram_slave.sv
// Self-checking bench for spi_sram_slave: frame vector table, strobe scoreboard, reset/burst sequences.
`timescale 1ns/1ps
module tb_spi_sram_slave;

  logic       sck, rst, cs_n, mosi;
  logic       miso, mem_we, mem_re, busy;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] tbmem [32];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [4:0] rq[$];

  typedef struct {
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] data;
    int         nbits;
    logic       exp_we;
    logic       exp_re;
    logic [4:0] exp_addr;
    logic [7:0] exp_data;
    logic       chk_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs[9];

  spi_sram_slave dut (
    .sck       (sck),
    .rst       (rst),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  assign mem_rdata = tbmem[mem_addr];

  initial sck = 1'b0;
  always #5 sck = ~sck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Strobe scoreboard: every mem_we/mem_re pulse must match the oldest expectation
  always @(posedge sck) begin
    #1;
    if (rst) begin
      if (mem_we || mem_re) chk("we_re_exclusive", {31'b0, mem_we & mem_re}, 32'd0);
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_we actual addr=%0h data=%0h required none", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("we_addr", {27'b0, mem_addr}, {27'b0, e.a});
          chk("we_data", {24'b0, mem_wdata}, {24'b0, e.d});
        end
      end
      if (mem_re) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_re actual addr=%0h required none", mem_addr);
        end else begin
          logic [4:0] ea;
          ea = rq.pop_front();
          chk("re_addr", {27'b0, mem_addr}, {27'b0, ea});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_frame(input logic [31:0] w, input int n,
                             output logic [7:0] rx, output logic anym, output logic allbusy);
    rx = '0; anym = 1'b0; allbusy = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge sck);
      cs_n = 1'b0;
      mosi = w[31-i];
      @(posedge sck);
      #1;
      if (i >= 16 && i < 24) rx = {rx[6:0], miso};
      anym    = anym | miso;
      allbusy = allbusy & busy;
    end
  endtask

  task automatic end_frame(input string tag);
    @(negedge sck);
    cs_n = 1'b1;
    mosi = 1'b0;
    @(posedge sck);
    #1;
    chk({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_pending_strobes"}, wq.size() + rq.size(), 32'd0);
    wq.delete();
    rq.delete();
  endtask

  initial begin
    logic [7:0] rx;
    logic       anym, ab;
    wr_t        w;

    for (int unsigned i = 0; i < 32; i++) tbmem[i] = 8'(i * 3 + 1);
    tbmem[31] = 8'h3C;

    //            op     addr   data   n   we    re    eaddr  edata  rx    emiso
    vecs[0] = '{8'h02, 8'h05, 8'hA5, 24, 1'b1, 1'b0, 5'd5,  8'hA5, 1'b0, 8'h00};
    vecs[1] = '{8'h03, 8'h1F, 8'h00, 24, 1'b0, 1'b1, 5'd31, 8'h00, 1'b1, 8'h3C};
    vecs[2] = '{8'h7E, 8'h00, 8'hFF, 24, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h00};
    vecs[3] = '{8'h02, 8'h03, 8'h77, 21, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h00};
    vecs[4] = '{8'h02, 8'h02, 8'h11, 24, 1'b1, 1'b0, 5'd2,  8'h11, 1'b0, 8'h00};
    vecs[5] = '{8'h02, 8'hE7, 8'h5A, 24, 1'b1, 1'b0, 5'd7,  8'h5A, 1'b0, 8'h00};
    vecs[6] = '{8'h03, 8'h04, 8'hFF, 24, 1'b0, 1'b1, 5'd4,  8'h00, 1'b1, 8'h0D};
    vecs[7] = '{8'h00, 8'h0A, 8'h55, 24, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 8'h00};
    vecs[8] = '{8'h03, 8'h09, 8'h00, 16, 1'b0, 1'b1, 5'd9,  8'h00, 1'b0, 8'h00};

    rst = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #12;
    chk("rst_miso",  {31'b0, miso},      32'd0);
    chk("rst_we",    {31'b0, mem_we},    32'd0);
    chk("rst_re",    {31'b0, mem_re},    32'd0);
    chk("rst_addr",  {27'b0, mem_addr},  32'd0);
    chk("rst_wdata", {24'b0, mem_wdata}, 32'd0);
    chk("rst_busy",  {31'b0, busy},      32'd0);
    @(negedge sck);
    rst = 1'b1;
    @(negedge sck);

    for (int unsigned k = 0; k < 9; k++) begin
      if (vecs[k].exp_we) begin
        w.a = vecs[k].exp_addr; w.d = vecs[k].exp_data;
        wq.push_back(w);
      end
      if (vecs[k].exp_re) rq.push_back(vecs[k].exp_addr);
`ifdef SPI_SRAM_AUTOINC_EN
      if (vecs[k].exp_re && vecs[k].nbits == 24) rq.push_back(vecs[k].exp_addr + 5'd1);
`endif
      drive_frame({vecs[k].op, vecs[k].addr, vecs[k].data, 8'h00}, vecs[k].nbits, rx, anym, ab);
      chk($sformatf("v%0d_busy_frame", k), {31'b0, ab}, 32'd1);
      if (vecs[k].chk_rx)
        chk($sformatf("v%0d_miso_byte", k), {24'b0, rx}, {24'b0, vecs[k].exp_miso});
      else if (!vecs[k].exp_re)
        chk($sformatf("v%0d_miso_zero", k), {31'b0, anym}, 32'd0);
      end_frame($sformatf("v%0d", k));
    end

    // Reset asserted between edges in the middle of a READ data phase
    rq.push_back(5'd31);
    drive_frame({8'h03, 8'h1F, 8'h00, 8'h00}, 20, rx, anym, ab);
    @(negedge sck);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_miso",  {31'b0, miso},      32'd0);
    chk("midrst_we",    {31'b0, mem_we},    32'd0);
    chk("midrst_re",    {31'b0, mem_re},    32'd0);
    chk("midrst_addr",  {27'b0, mem_addr},  32'd0);
    chk("midrst_wdata", {24'b0, mem_wdata}, 32'd0);
    chk("midrst_busy",  {31'b0, busy},      32'd0);
    chk("midrst_read_seen", rq.size(), 32'd0);
    cs_n = 1'b1;
    @(negedge sck);
    @(negedge sck);
    rst = 1'b1;

    w.a = 5'd12; w.d = 8'hC3;
    wq.push_back(w);
    drive_frame({8'h02, 8'h0C, 8'hC3, 8'h00}, 24, rx, anym, ab);
    end_frame("post_rst_write");

    // Two data bytes in one frame: second is a burst write only when auto-increment is built in
    w.a = 5'd31; w.d = 8'h01;
    wq.push_back(w);
`ifdef SPI_SRAM_AUTOINC_EN
    w.a = 5'd0; w.d = 8'h02;
    wq.push_back(w);
`endif
    drive_frame({8'h02, 8'h1F, 8'h01, 8'h02}, 32, rx, anym, ab);
    chk("burst_busy_frame", {31'b0, ab}, 32'd1);
    end_frame("burst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
